// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
//   Issue controller between the fetch stage and a free-running decoder.
//   It accepts instructions from fetch over a valid/ready handshake and
//   registers them onto the decoder inputs. When it cannot issue, it drives
//   a NOP instead. A per-register busy scoreboard blocks load-use hazards,
//   and a flush kills all in-flight work. A valid shift pipeline tracks
//   each instruction so that oIssueValid lines up with the decoder outputs.
//
// Ports
//   iClk, iRst           clock (rising edge), async active-low reset
//   iFetchValid/Inst/Pc  instruction offered by fetch
//   oFetchReady          instruction is accepted this cycle (combinational)
//   oDecInst/oDecPc      registered decoder inputs (NOP when idle)
//   oDecValid            oDecInst holds a real instruction
//   oIssueValid          decoder outputs are valid this cycle
//   iFlush               redirect; kills all younger work
//   iWbValid/iWbAddr     load writeback completion, frees a busy register
//   oBubbleCnt           saturating count of stalled fetch cycles
module decode_issue_ctrl #(
    parameter int unsigned cXLEN       = 32,
    parameter int unsigned cRegSelBitW = 5,
    parameter int unsigned cDecLat     = 2,
    parameter int unsigned cCntW       = 16
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iFetchValid,
    input  logic [cXLEN-1:0]       iFetchInst,
    input  logic [cXLEN-1:0]       iFetchPc,
    output logic                   oFetchReady,
    output logic [cXLEN-1:0]       oDecInst,
    output logic [cXLEN-1:0]       oDecPc,
    output logic                   oDecValid,
    output logic                   oIssueValid,
    input  logic                   iFlush,
    input  logic                   iWbValid,
    input  logic [cRegSelBitW-1:0] iWbAddr,
    output logic [cCntW-1:0]       oBubbleCnt
);

    localparam int unsigned    cNumRegs = 1 << cRegSelBitW;
    localparam logic [cXLEN-1:0] cNopInst = cXLEN'(32'h0000_0013);

    localparam logic [6:0] cOpLoad   = 7'b0000011;
    localparam logic [6:0] cOpStore  = 7'b0100011;
    localparam logic [6:0] cOpReg    = 7'b0110011;
    localparam logic [6:0] cOpImm    = 7'b0010011;
    localparam logic [6:0] cOpBranch = 7'b1100011;
    localparam logic [6:0] cOpJalr   = 7'b1100111;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t                               state_q, state_d;
    logic [cNumRegs-1:0]                  busy_q, busy_d;
    logic [cDecLat:0]                     vld_q, vld_d;
    logic [cDecLat:0]                     ld_q, ld_d;
    logic [cDecLat:0][cRegSelBitW-1:0]    rd_q, rd_d;
    logic [cXLEN-1:0]                     inst_q, inst_d;
    logic [cXLEN-1:0]                     pc_q, pc_d;
    logic [cCntW-1:0]                     cnt_q, cnt_d;

    logic [6:0]             opcode;
    logic [cRegSelBitW-1:0] rd, rs1, rs2;
    logic                   isLoad, usesRs1, usesRs2;
    logic                   hazard, fetchReady, accept;

    assign opcode = iFetchInst[6:0];
    assign rd     = iFetchInst[7 +: cRegSelBitW];
    assign rs1    = iFetchInst[15 +: cRegSelBitW];
    assign rs2    = iFetchInst[20 +: cRegSelBitW];

    assign isLoad  = (opcode == cOpLoad);
    assign usesRs1 = isLoad || (opcode == cOpStore) || (opcode == cOpReg) ||
                     (opcode == cOpImm) || (opcode == cOpBranch) || (opcode == cOpJalr);
    assign usesRs2 = (opcode == cOpStore) || (opcode == cOpReg) || (opcode == cOpBranch);

    // Scoreboard is read as registered state only: a writeback clear is seen next cycle.
    assign hazard = iFetchValid && ((usesRs1 && busy_q[rs1]) || (usesRs2 && busy_q[rs2]));

    // iRst gating keeps ready low while reset is held.
    assign fetchReady = iRst && (state_q != FLUSH) && !hazard && !iFlush;
    assign accept     = iFetchValid && fetchReady;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (iFlush) state_d = FLUSH; else if (hazard)  state_d = STALL;
            STALL:   if (iFlush) state_d = FLUSH; else if (!hazard) state_d = RUN;
            FLUSH:   if (iFlush) state_d = FLUSH; else              state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        vld_d  = {vld_q[cDecLat-1:0], accept};
        ld_d   = {ld_q[cDecLat-1:0], accept && isLoad};
        rd_d   = {rd_q[cDecLat-1:0], rd};
        inst_d = accept ? iFetchInst : cNopInst;
        pc_d   = accept ? iFetchPc : pc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (iFetchValid && !fetchReady && (cnt_q != '1)) begin
            cnt_d = cnt_q + cCntW'(1);
        end

        if (iWbValid) begin
            busy_d[iWbAddr] = 1'b0;
        end

        // Loads killed by a flush will never write back, so release their registers.
        if (iFlush) begin
            for (int unsigned i = 0; i <= cDecLat; i++) begin
                if (vld_q[i] && ld_q[i]) begin
                    busy_d[rd_q[i]] = 1'b0;
                end
            end
            vld_d = '0;
            ld_d  = '0;
        end

        // Applied after the clears so a same-cycle set wins.
        if (accept && isLoad && (rd != '0)) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= RUN;
            busy_q  <= '0;
            vld_q   <= '0;
            ld_q    <= '0;
            rd_q    <= '0;
            inst_q  <= cNopInst;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oFetchReady = fetchReady;
    assign oDecInst    = inst_q;
    assign oDecPc      = pc_q;
    assign oDecValid   = vld_q[0];
    assign oIssueValid = vld_q[cDecLat];
    assign oBubbleCnt  = cnt_q;

endmodule
